store_buffer: RTL and testbench



---
 rtl/store_buffer_if.sv | 33 +++
 rtl/store_buffer.sv | 129 ++++++++++++
 tb/tb_store_buffer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Load/store request bus between datapath and store buffer, plus the data_memory port.
// Signal-only bundle, no latency of its own.
// Backpressure: st_ready from the buffer; loads are never stalled.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_fwd;
    logic              flush;
    logic              empty;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] write_data;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] read_data;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, flush, read_data,
        input  st_ready, ld_data, ld_fwd, empty, mem_address, write_data, MemWrite, MemRead
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, flush, read_data,
        output st_ready, ld_data, ld_fwd, empty, mem_address, write_data, MemWrite, MemRead
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of data_memory with youngest-match load forwarding.
// Latency: stores accepted in 1 cycle, drained on idle port cycles; loads answer combinationally.
// Backpressure: st_ready low when full or flushing. STORE_BUF_COALESCE_EN merges a store into the youngest entry.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              empty, full, hit, mem_rd, pop, push, coal, coal_hit, st_rdy;
    logic [PTR_W-1:0]  youngest, idx;
    logic [DATA_W-1:0] fwd_data;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign youngest = tail_q - PTR_W'(1);

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (bus.ld_valid && vld_q[idx] && (addr_q[idx] == bus.ld_addr)) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign mem_rd = bus.ld_valid && !hit;
    assign pop    = !mem_rd && !empty;

`ifdef STORE_BUF_COALESCE_EN
    // Merging into an entry that is leaving this cycle would lose the store.
    assign coal_hit = !empty && (addr_q[youngest] == bus.st_addr) &&
                      !(pop && (count_q == (PTR_W+1)'(1)));
`else
    assign coal_hit = 1'b0;
`endif

    assign st_rdy = (state_q == RUN) && (!full || coal_hit);
    assign coal   = bus.st_valid && st_rdy && coal_hit;
    assign push   = bus.st_valid && st_rdy && !coal_hit;

    always_comb begin
        bus.MemRead     = mem_rd;
        bus.MemWrite    = pop;
        bus.mem_address = '0;
        bus.write_data  = '0;
        if (mem_rd) begin
            bus.mem_address = bus.ld_addr;
        end else if (pop) begin
            bus.mem_address = addr_q[head_q];
            bus.write_data  = data_q[head_q];
        end
    end

    assign bus.ld_fwd   = hit;
    assign bus.ld_data  = hit ? fwd_data : (mem_rd ? bus.read_data : '0);
    assign bus.st_ready = st_rdy;
    assign bus.empty    = empty;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        vld_d  = vld_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PTR_W'(1);
        end
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:   if (bus.flush && !empty) state_d = FLUSH;
            FLUSH: if (count_d == '0)       state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            if (push) begin
                addr_q[tail_q] <= bus.st_addr;
                data_q[tail_q] <= bus.st_data;
            end
            if (coal) begin
                data_q[youngest] <= bus.st_data;
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: queue-based reference model, scoreboard of per-cycle expected outputs.
// Memory model behind the port; program-order load values checked every cycle.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic        st_ready;
        logic        empty;
        logic        ld_fwd;
        logic        mem_write;
        logic        mem_read;
        logic [31:0] mem_address;
        logic [31:0] write_data;
        logic [31:0] ld_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    logic final_req = 1'b0;
    logic final_done = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // data_memory stand-in: 16 words, combinational read, posedge write
    logic [31:0] tbmem [16];
    assign bus.read_data = tbmem[bus.mem_address[5:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) tbmem[i] <= 32'h0;
        end else if (bus.MemWrite) begin
            tbmem[bus.mem_address[5:2]] <= bus.write_data;
        end
    end

    // Reference model: pending stores in order, memory image, program-order image
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] ref_mem [16];
    logic [31:0] prog [16];
    logic        flushing = 1'b0;
    exp_t        exp_q[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (final_req && !final_done) begin
            for (int i = 0; i < 16; i++) chk("memory_image", tbmem[i], ref_mem[i]);
            chk("leftover_expectations", 32'(exp_q.size()), 32'd0);
            final_done = 1'b1;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("st_ready", 32'(bus.st_ready), 32'(e.st_ready));
            chk("empty", 32'(bus.empty), 32'(e.empty));
            chk("ld_fwd", 32'(bus.ld_fwd), 32'(e.ld_fwd));
            chk("MemWrite", 32'(bus.MemWrite), 32'(e.mem_write));
            chk("MemRead", 32'(bus.MemRead), 32'(e.mem_read));
            chk("mem_address", bus.mem_address, e.mem_address);
            chk("ld_data", bus.ld_data, e.ld_data);
            if (e.mem_write) chk("write_data", bus.write_data, e.write_data);
        end
    end

    task automatic step(input logic lv, input logic [31:0] la, input logic sv,
                        input logic [31:0] sa, input logic [31:0] sd, input logic fl);
        exp_t e;
        logic hit, rd, wr, coal_ok, acc;
        int   n;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.flush    = fl;
        n   = qa.size();
        hit = 1'b0;
        if (lv) foreach (qa[i]) if (qa[i] == la) hit = 1'b1;
        rd = lv && !hit;
        wr = !rd && (n > 0);
        coal_ok = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        coal_ok = (n > 0) && (qa[n-1] == sa) && !(wr && n == 1);
`endif
        e.st_ready    = !flushing && ((n < DEPTH) || coal_ok);
        e.empty       = (n == 0);
        e.ld_fwd      = hit;
        e.mem_read    = rd;
        e.mem_write   = wr;
        e.mem_address = rd ? la : (wr ? qa[0] : 32'h0);
        e.write_data  = wr ? qd[0] : 32'h0;
        e.ld_data     = lv ? prog[la[5:2]] : 32'h0;
        exp_q.push_back(e);

        acc = sv && e.st_ready;
        if (wr) begin
            ref_mem[qa[0][5:2]] = qd[0];
            void'(qa.pop_front());
            void'(qd.pop_front());
        end
        if (acc) begin
            prog[sa[5:2]] = sd;
            if (coal_ok) begin
                qd[qd.size()-1] = sd;
            end else begin
                qa.push_back(sa);
                qd.push_back(sd);
            end
        end
        if (flushing) begin
            if (qa.size() == 0) flushing = 1'b0;
        end else if (fl && n > 0) begin
            flushing = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One cycle of reset asserted mid-run: pending stores vanish, memory keeps its contents.
    task automatic pulse_reset();
        rst_n = 1'b0;
        qa.delete();
        qd.delete();
        flushing = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = ref_mem[i];
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rs;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.flush    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h0;
            prog[i]    = 32'h0;
        end
        @(posedge clk);
        #1;
        mem_clr = 1'b0;
        pulse_reset();

        // single store drains on the next idle cycle
        step(1'b0, 32'h0, 1'b1, 32'h10, 32'hAA, 1'b0);
        idle(2);

        // load miss stalls draining while the buffer fills
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'h30, i < 6, 32'(i * 4), 32'h100 + 32'(i), 1'b0);
        idle(5);

        // two stores to the same address, youngest forwarded
        step(1'b1, 32'h30, 1'b1, 32'h20, 32'h1, 1'b0);
        step(1'b1, 32'h30, 1'b1, 32'h20, 32'h2, 1'b0);
        step(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(3);
        step(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);

        // flush with three entries while stores keep arriving
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h3C, 1'b1, 32'h24 + 32'(i * 4), 32'h200 + 32'(i), 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h34, 32'h55, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 1'b1, 32'h38, 32'h300 + 32'(i), 1'b0);
        idle(3);

        // reset with two entries pending
        step(1'b1, 32'h3C, 1'b1, 32'h08, 32'hDEAD, 1'b0);
        step(1'b1, 32'h3C, 1'b1, 32'h0C, 32'hBEEF, 1'b0);
        pulse_reset();
        step(1'b1, 32'h08, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 32'h0C, 1'b0, 32'h0, 32'h0, 1'b0);

        // full buffer, then a store to the youngest address
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h3C, 1'b1, 32'h00 + 32'(i * 4), 32'h400 + 32'(i), 1'b0);
        step(1'b1, 32'h3C, 1'b1, 32'h0C, 32'h77, 1'b0);
        step(1'b1, 32'h0C, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(6);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                pulse_reset();
            end else begin
                ra = 32'($urandom_range(0, 7)) * 32'd4;
                rs = 32'($urandom_range(0, 7)) * 32'd4;
                step($urandom_range(0, 99) < 45, ra, $urandom_range(0, 99) < 60, rs,
                     32'($urandom), $urandom_range(0, 99) < 5);
            end
        end
        idle(8);

        @(negedge clk);
        #1;
        final_req = 1'b1;
        @(negedge clk);
        #1;
        if (!final_done) begin
            fails++;
            $display("FAIL final_check: got not-run expected run");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
